// File: rtl/audio_mix_if.sv
// Sample/configuration/output bundle for the audio mixing engine.
interface audio_mix_if;
  logic               sample_stb;
  logic [127:0]       src_l;
  logic [127:0]       src_r;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [7:0]         cfg_data;
  logic signed [15:0] audio_l;
  logic signed [15:0] audio_r;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output sample_stb, src_l, src_r, cfg_we, cfg_addr, cfg_data,
    input  audio_l, audio_r, out_valid, busy, overrun
  );

  modport slave (
    input  sample_stb, src_l, src_r, cfg_we, cfg_addr, cfg_data,
    output audio_l, audio_r, out_valid, busy, overrun
  );
endinterface

// File: rtl/audio_mix_scheduler.sv
// Time-multiplexed stereo mixer: snapshot eight sources on a strobe, scale
// and accumulate one slot per clock through a shared MAC, saturate, present.
//
// state | meaning
// IDLE  | waiting for sample_stb; snapshot taken on the accepting edge
// ACC   | one slot per cycle added into acc_l/acc_r
// SAT   | saturate (or mute) accumulators into the output registers
module audio_mix_scheduler #(
  parameter int NSLOT = 8
) (
  input logic        clk,
  input logic        reset,
  audio_mix_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] SAT  = 2'd2;
  localparam logic [2:0] LAST_SLOT = 3'(NSLOT - 1);

  logic [1:0]             state_q, state_d;
  logic [2:0]             slot_q, slot_d;
  logic signed [19:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [NSLOT-1:0][3:0]  gain_q, gain_d, sh_gain_q, sh_gain_d;
  logic [NSLOT-1:0]       en_q, en_d, sh_en_q, sh_en_d;
  logic                   mute_q, mute_d, sh_mute_q, sh_mute_d;
  logic [127:0]           sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic signed [15:0]     audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  logic signed [15:0] cur_l, cur_r;
  logic signed [4:0]  gain_s;
  logic signed [20:0] prod_l, prod_r;
  logic signed [16:0] term_l, term_r;
  logic               term_on;

  function automatic logic signed [15:0] sat16(input logic signed [19:0] a);
    if (!a[19] && (a[18:15] != 4'h0))     sat16 = 16'sh7FFF;
    else if (a[19] && (a[18:15] != 4'hF)) sat16 = 16'sh8000;
    else                                  sat16 = a[15:0];
  endfunction

  // Per-slot scaled term from the shadowed sample and gain (floor shift by 3).
  always_comb begin
    cur_l   = sh_l_q[{slot_q, 4'b0000} +: 16];
    cur_r   = sh_r_q[{slot_q, 4'b0000} +: 16];
    gain_s  = {1'b0, sh_gain_q[slot_q]};
    prod_l  = 21'(cur_l) * 21'(gain_s);
    prod_r  = 21'(cur_r) * 21'(gain_s);
    term_on = sh_en_q[slot_q] && (sh_gain_q[slot_q] != 4'd0);
    term_l  = term_on ? 17'(prod_l >>> 3) : 17'sd0;
    term_r  = term_on ? 17'(prod_r >>> 3) : 17'sd0;
  end

  // Next-state logic: FSM, datapath, live config and overrun flag.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    gain_d      = gain_q;
    en_d        = en_q;
    mute_d      = mute_q;
    sh_gain_d   = sh_gain_q;
    sh_en_d     = sh_en_q;
    sh_mute_d   = sh_mute_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
    audio_l_d   = audio_l_q;
    audio_r_d   = audio_r_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (bus.sample_stb) begin
          sh_l_d    = bus.src_l;
          sh_r_d    = bus.src_r;
          sh_gain_d = gain_q;
          sh_en_d   = en_q;
          sh_mute_d = mute_q;
          acc_l_d   = '0;
          acc_r_d   = '0;
          slot_d    = '0;
          state_d   = ACC;
        end
      end
      ACC: begin
        acc_l_d = acc_l_q + 20'(term_l);
        acc_r_d = acc_r_q + 20'(term_r);
        slot_d  = slot_q + 3'd1;
        if (slot_q == LAST_SLOT) state_d = SAT;
      end
      SAT: begin
        audio_l_d   = sh_mute_q ? 16'sd0 : sat16(acc_l_q);
        audio_r_d   = sh_mute_q ? 16'sd0 : sat16(acc_r_q);
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.cfg_we) begin
      if (!bus.cfg_addr[3]) begin
        gain_d[bus.cfg_addr[2:0]] = bus.cfg_data[3:0];
        en_d[bus.cfg_addr[2:0]]   = bus.cfg_data[7];
      end else if (bus.cfg_addr == 4'd8) begin
        mute_d = bus.cfg_data[0];
        if (bus.cfg_data[1]) overrun_d = 1'b0;
      end
    end

    // A dropped strobe must win over a same-cycle clear.
    if (bus.sample_stb && (state_q != IDLE)) overrun_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      gain_q      <= {NSLOT{4'd8}};
      en_q        <= '1;
      mute_q      <= 1'b0;
      sh_gain_q   <= {NSLOT{4'd8}};
      sh_en_q     <= '1;
      sh_mute_q   <= 1'b0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      gain_q      <= gain_d;
      en_q        <= en_d;
      mute_q      <= mute_d;
      sh_gain_q   <= sh_gain_d;
      sh_en_q     <= sh_en_d;
      sh_mute_q   <= sh_mute_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      audio_l_q   <= audio_l_d;
      audio_r_q   <= audio_r_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.audio_l   = audio_l_q;
  assign bus.audio_r   = audio_r_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Directed bench for audio_mix_scheduler; inputs driven and outputs sampled
// on the falling edge.
module tb_audio_mix_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  audio_mix_if bus ();

  audio_mix_scheduler #(.NSLOT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_src();
    bus.src_l = '0;
    bus.src_r = '0;
  endtask

  task automatic set_slot(input int k, input logic [15:0] l, input logic [15:0] r);
    bus.src_l[k*16 +: 16] = l;
    bus.src_r[k*16 +: 16] = r;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  // Strobe, then wait (bounded) for out_valid; lat = -1 on timeout.
  task automatic run_mix(output int lat, output logic [15:0] l, output logic [15:0] r);
    bus.sample_stb = 1'b1;
    @(negedge clk);
    bus.sample_stb = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    l = bus.audio_l;
    r = bus.audio_r;
  endtask

  task automatic test_reset();
    logic [15:0] got_l, got_r;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.audio_l !== 16'h0000) begin errors++; $display("FAIL reset_audio_l: got %h expected 0000", bus.audio_l); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    clear_src();
    set_slot(0, 16'h1000, 16'h1000);
    bus.sample_stb = 1'b1;
    @(negedge clk);
    bus.sample_stb = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_busy_cycle%0d: got busy=%b valid=%b expected busy=1 valid=0", c, bus.busy, bus.out_valid);
      end
      @(negedge clk);
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL reset_latency: out_valid got %b at cycle 10 expected 1", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_end: got %b expected 0", bus.busy); end
    got_l = bus.audio_l; got_r = bus.audio_r;
    checks++; if (got_l !== 16'h1000 || got_r !== 16'h1000) begin
      errors++; $display("FAIL reset_unity: got l=%h r=%h expected 1000/1000", got_l, got_r);
    end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_pulse: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_gain_floor();
    int lat; logic [15:0] l, r;
    cfg_write(4'd2, 8'h84);
    clear_src();
    set_slot(2, 16'h0003, 16'hFFFD);
    run_mix(lat, l, r);
    checks++; if (lat != 10) begin errors++; $display("FAIL gain_latency: got %0d expected 10", lat); end
    checks++; if (l !== 16'h0001 || r !== 16'hFFFE) begin
      errors++; $display("FAIL gain_floor: got l=%h r=%h expected 0001/fffe", l, r);
    end
    cfg_write(4'd2, 8'h88);
  endtask

  task automatic test_saturation();
    int lat; logic [15:0] l, r;
    for (int k = 0; k < 8; k++) cfg_write(4'(k), 8'h8F);
    for (int k = 0; k < 8; k++) set_slot(k, 16'h7FFF, 16'h7FFF);
    run_mix(lat, l, r);
    checks++; if (lat != 10 || l !== 16'h7FFF || r !== 16'h7FFF) begin
      errors++; $display("FAIL sat_pos: got lat=%0d l=%h r=%h expected 10 7fff/7fff", lat, l, r);
    end
    for (int k = 0; k < 8; k++) set_slot(k, 16'h8000, 16'h8000);
    run_mix(lat, l, r);
    checks++; if (lat != 10 || l !== 16'h8000 || r !== 16'h8000) begin
      errors++; $display("FAIL sat_neg: got lat=%0d l=%h r=%h expected 10 8000/8000", lat, l, r);
    end
    for (int k = 0; k < 8; k++) cfg_write(4'(k), 8'h88);
    clear_src();
    set_slot(0, 16'h6000, 16'h6000);
    set_slot(1, 16'h6000, 16'h6000);
    run_mix(lat, l, r);
    checks++; if (lat != 10 || l !== 16'h7FFF || r !== 16'h7FFF) begin
      errors++; $display("FAIL sat_unity_sum: got lat=%0d l=%h r=%h expected 10 7fff/7fff", lat, l, r);
    end
  endtask

  task automatic test_enable_mute();
    int lat; logic [15:0] l, r;
    cfg_write(4'd3, 8'h08);
    clear_src();
    set_slot(3, 16'h4000, 16'h4000);
    run_mix(lat, l, r);
    checks++; if (lat != 10 || l !== 16'h0000 || r !== 16'h0000) begin
      errors++; $display("FAIL disabled_slot: got lat=%0d l=%h r=%h expected 10 0000/0000", lat, l, r);
    end
    cfg_write(4'd8, 8'h01);
    cfg_write(4'd3, 8'h88);
    run_mix(lat, l, r);
    checks++; if (lat != 10 || l !== 16'h0000 || r !== 16'h0000) begin
      errors++; $display("FAIL mute: got lat=%0d l=%h r=%h expected 10 0000/0000", lat, l, r);
    end
    cfg_write(4'd8, 8'h00);
    run_mix(lat, l, r);
    checks++; if (lat != 10 || l !== 16'h4000 || r !== 16'h4000) begin
      errors++; $display("FAIL unmute: got lat=%0d l=%h r=%h expected 10 4000/4000", lat, l, r);
    end
  endtask

  task automatic test_overrun_shadow();
    int lat; int nvalid; logic [15:0] l, r, vl;
    clear_src();
    set_slot(0, 16'h0100, 16'h0100);
    vl = 16'hDEAD;
    nvalid = 0;
    bus.sample_stb = 1'b1;           // cycle 0
    @(negedge clk); bus.sample_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);                  // cycle 3: live gain[0] = 0
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 8'h80;
    @(negedge clk); bus.cfg_we = 1'b0;
    @(negedge clk);                  // cycle 5: strobe while busy
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b expected 0", bus.overrun); end
    bus.sample_stb = 1'b1;
    @(negedge clk); bus.sample_stb = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
    for (int c = 6; c <= 16; c++) begin
      if (bus.out_valid) begin nvalid++; vl = bus.audio_l; end
      @(negedge clk);
    end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL overrun_valid_count: got %0d expected 1", nvalid); end
    checks++; if (vl !== 16'h0100) begin errors++; $display("FAIL shadow_gain: got %h expected 0100", vl); end
    // Drop and clear in the same cycle: overrun must stay set.
    bus.sample_stb = 1'b1;
    @(negedge clk); bus.sample_stb = 1'b0;
    @(negedge clk);
    bus.sample_stb = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd8; bus.cfg_data = 8'h02;
    @(negedge clk);
    bus.sample_stb = 1'b0; bus.cfg_we = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins: got %b expected 1", bus.overrun); end
    lat = 3;
    while (!bus.out_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat != 10 || bus.audio_l !== 16'h0000) begin
      errors++; $display("FAIL new_gain_applies: got lat=%0d l=%h expected 10 0000", lat, bus.audio_l);
    end
    cfg_write(4'd8, 8'h02);
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", bus.overrun); end
    cfg_write(4'd0, 8'h88);
    run_mix(lat, l, r);
    checks++; if (lat != 10 || l !== 16'h0100 || r !== 16'h0100) begin
      errors++; $display("FAIL clear_not_mute: got lat=%0d l=%h r=%h expected 10 0100/0100", lat, l, r);
    end
  endtask

  task automatic test_reset_mid();
    int lat; int nvalid; logic [15:0] l, r;
    clear_src();
    set_slot(0, 16'h1000, 16'h1000);
    run_mix(lat, l, r);
    checks++; if (l !== 16'h1000) begin errors++; $display("FAIL pre_reset_mix: got %h expected 1000", l); end
    set_slot(1, 16'h0800, 16'h0800);
    bus.sample_stb = 1'b1;
    @(negedge clk); bus.sample_stb = 1'b0;
    repeat (4) @(negedge clk);       // cycle 5
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.audio_l !== 16'h0000 || bus.audio_r !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_state: got busy=%b l=%h r=%h expected 0 0000/0000", bus.busy, bus.audio_l, bus.audio_r);
    end
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid) nvalid++;
      @(negedge clk);
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL reset_mid_no_valid: got %0d pulses expected 0", nvalid); end
    run_mix(lat, l, r);
    checks++; if (lat != 10 || l !== 16'h1800 || r !== 16'h1800) begin
      errors++; $display("FAIL after_reset_mix: got lat=%0d l=%h r=%h expected 10 1800/1800", lat, l, r);
    end
  endtask

  initial begin
    bus.sample_stb = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.src_l      = '0;
    bus.src_r      = '0;
    @(negedge clk);
    test_reset();
    test_gain_floor();
    test_saturation();
    test_enable_mute();
    test_overrun_shadow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_mix_scheduler.md
# audio_mix_scheduler

Time-multiplexed stereo mixing engine with per-source gain control. It snapshots up to eight pre-formatted 16-bit signed sources (beeper, tape, PSG, FM, covox, SAA, GS, ADC) on each sample strobe. It then scales and accumulates them through a single shared multiply-accumulate datapath, one slot per clock. The saturated result is presented to the DAC/I2S/HDMI audio path with a one-cycle valid pulse. Gains, slot enables and mute are written by the CPU port decoder.

## Interface
Parameters:
- NSLOT, 8, number of source slots; fixed at 8 in this design.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  reset input: synchronous and active-high.
- sample_stb  in  1  one-cycle pulse requesting a new output sample (e.g. 48 kHz tick).
- src_l  in  128  slot k left sample at bits [16k+15:16k], signed.
- src_r  in  128  slot k right sample at bits [16k+15:16k], signed.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  4  configuration register address.
- cfg_data  in  8  configuration write data.
- audio_l  out  16  signed mixed left output; holds until the next update.
- audio_r  out  16  signed mixed right output; holds until the next update.
- out_valid  out  1  one-cycle pulse when audio_l/audio_r are updated.
- busy  out  1  high from the snapshot cycle through the final cycle of SAT.
- overrun  out  1  sticky flag: a strobe arrived while busy.

## Operation
- Configuration registers, written when cfg_we=1:
  - addr 0..7 write slot k: gain[k]=cfg_data[3:0] (0..15, where 8 = unity) and en[k]=cfg_data[7].
  - addr 8 bit 0 sets mute.
  - addr 8 bit 1 = 1 clears overrun; this bit is write-one-to-clear and is not stored.
  - addr 9..15 writes are ignored.
- Reset values:
  - gain[k]=8 and en[k]=1 for all k; mute=0.
  - audio_l=audio_r=0; out_valid=0; busy=0; overrun=0.
  - FSM in IDLE, slot counter 0, accumulators 0.
- FSM states: IDLE, ACC, SAT.
  - IDLE: when sample_stb=1, snapshot src_l, src_r, gain[], en[] and mute into shadow registers. Clear both accumulators and go to ACC with slot=0.
  - ACC: each cycle add term(slot) to acc_l and acc_r. Increment slot. After slot 7, go to SAT.
  - SAT: load audio_l/audio_r with the saturated accumulators, or with 0 if the shadowed mute=1. Assert out_valid for the next cycle and return to IDLE.
- Per-slot term:
  - If en=0 or gain=0, the term is 0.
  - Otherwise term = (sample × gain) >>> 3.
  - sample × gain is a 21-bit signed product; >>> is an arithmetic shift (floor rounding), giving a 17-bit signed term.
  - Accumulators are 20-bit signed. Worst case is 8 × 15 × 32768 / 8 = 491520, so the accumulator cannot wrap.
- Saturation: acc > 32767 gives 32767; acc < −32768 gives −32768; otherwise acc[15:0].
- Strobe while busy (in ACC or SAT): the strobe is dropped and overrun is set; the current mix is unaffected.
- Overrun set and clear in the same cycle: the set wins.
- Config writes during ACC/SAT update the live registers only. The mix in flight uses the shadow copy, so new values apply from the next strobe.
- Reset asserted mid-operation: return to reset values on that edge; the partial mix is discarded and out_valid is not pulsed.

## Timing
- Cycle 0: sample_stb is sampled high in IDLE and the snapshot is taken; busy=1 from cycle 1.
- Cycles 1..8: ACC for slots 0..7.
- Cycle 9: SAT.
- Cycle 10: audio_l/audio_r show the new value and out_valid=1; busy=0.
- Latency from strobe to out_valid is 10 cycles.
- Minimum strobe spacing is 10 cycles:
  - A strobe in cycle 10 (IDLE) is accepted.
  - Strobes in cycles 1..9 set overrun.
- Outputs are fully registered; no combinational path exists from inputs to outputs.
- overrun rises the cycle after the offending strobe.

## Test plan
- Reset defaults:
  - Stimulus: slot 0 = 0x1000 on L and R, other slots 0, strobe.
  - Expected: out_valid exactly 10 cycles later; audio_l = audio_r = 0x1000; busy high for cycles 1..9.
- Gain and floor rounding:
  - Stimulus: gain[2]=4; slot 2 L = 0x0003, slot 2 R = −3 (0xFFFD), others 0.
  - Expected: audio_l = 0x0001; audio_r = 0xFFFE (−2).
- Saturation:
  - Stimulus: all slots 0x7FFF with gain 15.
  - Expected: audio = 0x7FFF.
  - Stimulus: all slots 0x8000 with gain 15.
  - Expected: audio = 0x8000.
  - Stimulus: slots 0 and 1 at 0x6000, unity gain.
  - Expected: 0x7FFF.
- Enable and mute:
  - Stimulus: write addr 3 = 0x08 (en=0); slot 3 = 0x4000, others 0.
  - Expected: output 0.
  - Stimulus: write addr 8 = 0x01; re-enable slot 3.
  - Expected: output 0 with out_valid still pulsed; after writing addr 8 = 0x00, output 0x4000.
- Overrun and shadowing:
  - Stimulus: strobe at cycles 0 and 5, plus a cfg write gain[0]=0 at cycle 3 (slot 0 = 0x0100).
  - Expected: one out_valid with value 0x0100; overrun=1 from cycle 6.
  - Stimulus: next strobe, then write addr 8 = 0x02.
  - Expected: output 0x0000; overrun clears.
- Reset mid-mix:
  - Stimulus: assert reset at cycle 5 after a strobe.
  - Expected: no out_valid; audio = 0; busy = 0 the next cycle.
  - Stimulus: a strobe after reset.
  - Expected: normal 10-cycle result.
